// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges load-use and divide holds into the per-stage hold
// vector and runs the start/annul handshake to the shared iterative divider with a watchdog.
module pipe_stall_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id_i,
  input  logic       div_req_i,
  input  logic       div_signed_i,
  input  logic       div_ready_i,
  input  logic       annul_i,
  output logic [5:0] stall_o,
  output logic       div_start_o,
  output logic       div_signed_o,
  output logic       div_annul_o,
  output logic       div_busy_o,
  output logic       div_timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [5:0]       HOLD_DIV  = 6'b001111;
  localparam logic [5:0]       HOLD_ID   = 6'b000111;
  localparam logic [5:0]       HOLD_NONE = 6'b000000;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             div_hold_s;

  // Next-state, divider handshake pulses and stall merge
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    signed_d      = signed_q;
    div_hold_s    = 1'b0;
    div_start_o   = 1'b0;
    div_annul_o   = 1'b0;
    div_busy_o    = 1'b0;
    div_timeout_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (div_req_i && !annul_i) begin
          state_d    = ST_START;
          signed_d   = div_signed_i;
          cnt_d      = {CNT_W{1'b0}};
          div_hold_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        div_start_o = 1'b1;
        div_busy_o  = 1'b1;
        div_hold_s  = 1'b1;
        if (annul_i) begin
          div_annul_o = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        div_busy_o = 1'b1;
        div_hold_s = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        // Flush beats a result arriving in the same cycle; a result beats the watchdog.
        if (annul_i) begin
          div_annul_o = 1'b1;
          state_d     = ST_IDLE;
        end else if (div_ready_i) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          div_timeout_o = 1'b1;
          div_annul_o   = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (annul_i) begin
      stall_o = HOLD_NONE;
    end else if (div_hold_s) begin
      stall_o = HOLD_DIV;
    end else if (stallreq_id_i) begin
      stall_o = HOLD_ID;
    end else begin
      stall_o = HOLD_NONE;
    end
  end

  // State, watchdog counter and latched signedness
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
    end
  end

  assign div_signed_o = signed_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, multi-cycle sequences,
// then randomized traffic against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int DIV_TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst, stallreq_id_i, div_req_i, div_signed_i, div_ready_i, annul_i;
  logic [5:0] stall_o;
  logic       div_start_o, div_signed_o, div_annul_o, div_busy_o, div_timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id_i(stallreq_id_i), .div_req_i(div_req_i), .div_signed_i(div_signed_i),
    .div_ready_i(div_ready_i), .annul_i(annul_i),
    .stall_o(stall_o), .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_annul_o(div_annul_o), .div_busy_o(div_busy_o), .div_timeout_o(div_timeout_o)
  );

  // Expected outputs packed as {stall[5:0], start, signed, annul, busy, timeout}
  function automatic logic [10:0] pk(logic [5:0] st, logic s, logic sg, logic a, logic b, logic t);
    return {st, s, sg, a, b, t};
  endfunction

  typedef struct {
    logic        r, sid, req, sg, rdy, an;
    logic [10:0] exp;
  } vec_t;

  task automatic drive(logic r, logic sid, logic req, logic sg, logic rdy, logic an);
    rst = r; stallreq_id_i = sid; div_req_i = req; div_signed_i = sg;
    div_ready_i = rdy; annul_i = an;
    @(negedge clk);
  endtask

  task automatic check(string name, int idx, logic [10:0] exp);
    logic [10:0] act;
    act = {stall_o, div_start_o, div_signed_o, div_annul_o, div_busy_o, div_timeout_o};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got stall=%b start=%b signed=%b annul=%b busy=%b timeout=%b, want stall=%b start=%b signed=%b annul=%b busy=%b timeout=%b",
                  name, idx, act[10:5], act[4], act[3], act[2], act[1], act[0],
                  exp[10:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  task automatic cyc(string name, int idx, logic r, logic sid, logic req, logic sg,
                     logic rdy, logic an, logic [10:0] exp);
    drive(r, sid, req, sg, rdy, an);
    check(name, idx, exp);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];
  bit   m_active, m_done, m_sign;
  int   m_age;

  initial begin
    // Directed vectors, each row is one cycle: inputs, then outputs expected in that cycle
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, pk(6'b000000,1'b0,1'b0,1'b0,1'b0,1'b0)};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, pk(6'b000111,1'b0,1'b0,1'b0,1'b0,1'b0)};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, pk(6'b000000,1'b0,1'b0,1'b0,1'b0,1'b0)};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, pk(6'b000000,1'b0,1'b0,1'b0,1'b0,1'b0)};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, pk(6'b001111,1'b0,1'b0,1'b0,1'b0,1'b0)};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, pk(6'b000000,1'b1,1'b0,1'b1,1'b1,1'b0)};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, pk(6'b001111,1'b0,1'b0,1'b0,1'b0,1'b0)};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, pk(6'b001111,1'b1,1'b1,1'b0,1'b1,1'b0)};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, pk(6'b001111,1'b0,1'b1,1'b0,1'b1,1'b0)};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, pk(6'b001111,1'b0,1'b1,1'b0,1'b1,1'b0)};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, pk(6'b000111,1'b0,1'b1,1'b0,1'b0,1'b0)};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, pk(6'b000000,1'b0,1'b1,1'b0,1'b0,1'b0)};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, pk(6'b001111,1'b0,1'b1,1'b0,1'b0,1'b0)};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, pk(6'b001111,1'b1,1'b0,1'b0,1'b1,1'b0)};
    vecs[14] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, pk(6'b000000,1'b0,1'b0,1'b1,1'b1,1'b0)};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, pk(6'b000000,1'b0,1'b0,1'b0,1'b0,1'b0)};

    rst = 1'b1; stallreq_id_i = 1'b0; div_req_i = 1'b0; div_signed_i = 1'b0;
    div_ready_i = 1'b0; annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++)
      cyc("table", i, vecs[i].r, vecs[i].sid, vecs[i].req, vecs[i].sg, vecs[i].rdy, vecs[i].an,
          vecs[i].exp);

    // Signed divide, result 10 cycles after START: 12 held cycles then one DONE cycle
    for (int c = 0; c < 14; c++)
      cyc("div_ready", c, 1'b0, 1'b0, c <= 12, 1'b1, c == 11, 1'b0,
          pk((c <= 11) ? 6'b001111 : 6'b000000, c == 1, c >= 1, 1'b0, c >= 1 && c <= 11, 1'b0));

    // Flush in the 3rd BUSY cycle, then a late result that must be ignored
    for (int c = 0; c < 7; c++)
      cyc("annul_busy", c, 1'b0, 1'b0, c <= 4, 1'b0, c == 5, c == 4,
          pk((c <= 3) ? 6'b001111 : 6'b000000, c == 1, c == 0, c == 4, c >= 1 && c <= 4, 1'b0));

    // Divider never answers: watchdog fires on BUSY cycle DIV_TIMEOUT
    for (int c = 0; c < DIV_TIMEOUT + 3; c++)
      cyc("timeout", c, 1'b0, 1'b0, c <= DIV_TIMEOUT + 1, 1'b1, 1'b0, 1'b0,
          pk((c <= DIV_TIMEOUT + 1) ? 6'b001111 : 6'b000000, c == 1, c >= 1,
             c == DIV_TIMEOUT + 1, c >= 1 && c <= DIV_TIMEOUT + 1, c == DIV_TIMEOUT + 1));

    // ID request under a divide hold, then back-to-back divides
    for (int c = 0; c < 10; c++)
      cyc("back2back", c, 1'b0, c == 2 || c == 3, c <= 7, 1'b0, c == 3 || c == 7, 1'b0,
          pk((c <= 3 || (c >= 5 && c <= 7)) ? 6'b001111 : 6'b000000, c == 1 || c == 6, c == 0,
             1'b0, (c >= 1 && c <= 3) || c == 6 || c == 7, 1'b0));

    // Reset in BUSY: no annul, everything quiet afterwards
    for (int c = 0; c < 6; c++)
      cyc("rst_busy", c, c == 3, 1'b0, c <= 2, 1'b1, 1'b0, 1'b0,
          pk((c <= 3) ? 6'b001111 : 6'b000000, c == 1, c >= 1 && c <= 3, 1'b0,
             c >= 1 && c <= 3, 1'b0));

    // Randomized traffic against the behavioural model (starts from the post-reset idle state)
    m_active = 1'b0; m_done = 1'b0; m_sign = 1'b0; m_age = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, sid, req, sg, rdy, an, hold, st, to, ab;
      logic [5:0] es;
      r   = ($urandom % 300) == 0;
      sid = ($urandom % 3) == 0;
      req = ($urandom % 4) != 0;
      sg  = $urandom % 2;
      rdy = ($urandom % 25) == 0;
      an  = ($urandom % 30) == 0;
      hold = m_active || (!m_done && req);
      es   = an ? 6'b000000 : hold ? 6'b001111 : sid ? 6'b000111 : 6'b000000;
      st   = m_active && m_age == 0;
      to   = m_active && m_age >= 1 && !an && !rdy && m_age == DIV_TIMEOUT;
      ab   = (m_active && an) || to;
      drive(r, sid, req, sg, rdy, an);
      check("random", n, pk(es, st, m_sign, ab, m_active, to));
      if (r) begin
        m_active = 1'b0; m_done = 1'b0; m_sign = 1'b0;
      end else if (m_active) begin
        if (an || to) m_active = 1'b0;
        else if (m_age >= 1 && rdy) begin m_active = 1'b0; m_done = 1'b1; end
        else m_age++;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (req && !an) begin
        m_active = 1'b1; m_age = 0; m_sign = sg;
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
